// File: rtl/pipe_hazard_ctrl.sv
// Central IF/ID/EX/MEM/WB sequencer: hazard stalls, flushes, halt drain, memory watchdog.
// Optional perf counters enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
   parameter int REG_AW       = 4,
   parameter int DRAIN_CYCLES = 3,
   parameter int MEM_TIMEOUT  = 255,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hlt,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_reg_write,
   input  logic              br_taken,
   input  logic              mem_busy,
   output logic              pc_we,
   output logic              ifid_we,
   output logic              ifid_flush,
   output logic              idex_we,
   output logic              idex_bubble,
   output logic              exmem_we,
   output logic              exmem_flush,
   output logic              memwb_bubble,
   output logic              stall,
   output logic              halted,
   output logic              mem_err,
   output logic [1:0]        state,
   output logic [CNT_W-1:0]  perf_stall_cnt,
   output logic [CNT_W-1:0]  perf_flush_cnt
);

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_DRAIN  = 2'd1,
      S_HALTED = 2'd2,
      S_ERROR  = 2'd3
   } state_t;

   localparam logic [7:0] BUSY_LAST  = 8'(MEM_TIMEOUT - 1);
   localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

   state_t     state_q, state_d;
   logic [3:0] drain_cnt_q, drain_cnt_d;
   logic [7:0] busy_cnt_q, busy_cnt_d;
   logic       mem_err_q, mem_err_d;

   logic lu;
   logic active;
   logic rs_hit;
   logic rt_hit;

   always_comb begin
      rs_hit = id_uses_rs & (id_rs == ex_rd);
      rt_hit = id_uses_rt & (id_rt == ex_rd);
      lu     = ex_mem_read & ex_reg_write & (ex_rd != '0) & (rs_hit | rt_hit);
      active = (state_q == S_RUN) | (state_q == S_DRAIN);
   end

   always_comb begin
      pc_we        = 1'b1;
      ifid_we      = 1'b1;
      idex_we      = 1'b1;
      exmem_we     = 1'b1;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_flush  = 1'b0;
      memwb_bubble = 1'b0;
      halted       = 1'b0;
      if (rst) begin
         pc_we        = 1'b0;
         ifid_we      = 1'b0;
         idex_we      = 1'b0;
         exmem_we     = 1'b0;
         ifid_flush   = 1'b1;
         idex_bubble  = 1'b1;
         exmem_flush  = 1'b1;
         memwb_bubble = 1'b1;
      end else if (!active) begin
         pc_we    = 1'b0;
         ifid_we  = 1'b0;
         idex_we  = 1'b0;
         exmem_we = 1'b0;
         halted   = 1'b1;
      end else if (mem_busy) begin
         pc_we        = 1'b0;
         ifid_we      = 1'b0;
         idex_we      = 1'b0;
         exmem_we     = 1'b0;
         memwb_bubble = 1'b1;
      end else if (br_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         exmem_flush = 1'b1;
      end else if ((state_q == S_DRAIN) | lu | hlt) begin
         // older instructions keep moving while ID is held
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   always_comb begin
      stall   = ~pc_we;
      mem_err = mem_err_q & ~rst;
      state   = state_q;
   end

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      busy_cnt_d  = '0;
      mem_err_d   = mem_err_q;
      if (active) begin
         if (mem_busy) begin
            busy_cnt_d = (busy_cnt_q == 8'hff) ? busy_cnt_q : busy_cnt_q + 8'd1;
            if (busy_cnt_q == BUSY_LAST) begin
               state_d   = S_ERROR;
               mem_err_d = 1'b1;
            end
         end else if (br_taken) begin
            // a HLT being drained was on the wrong path
            state_d     = S_RUN;
            drain_cnt_d = '0;
         end else if (state_q == S_DRAIN) begin
            if (drain_cnt_q == 4'd1) begin
               state_d     = S_HALTED;
               drain_cnt_d = '0;
            end else begin
               drain_cnt_d = drain_cnt_q - 4'd1;
            end
         end else if (!lu && hlt) begin
            state_d     = S_DRAIN;
            drain_cnt_d = DRAIN_INIT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_RUN;
         drain_cnt_q <= '0;
         busy_cnt_q  <= '0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         busy_cnt_q  <= busy_cnt_d;
         mem_err_q   <= mem_err_d;
      end
   end

`ifdef PIPE_HAZARD_PERF_EN
   logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
   logic [CNT_W-1:0] perf_flush_q, perf_flush_d;
   logic             stall_inc;
   logic             flush_inc;

   always_comb begin
      stall_inc    = active & ~pc_we;
      flush_inc    = active & ~mem_busy & br_taken;
      perf_stall_d = perf_stall_q;
      perf_flush_d = perf_flush_q;
      if (stall_inc && (perf_stall_q != '1)) begin
         perf_stall_d = perf_stall_q + 1'b1;
      end
      if (flush_inc && (perf_flush_q != '1)) begin
         perf_flush_d = perf_flush_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_flush_q <= perf_flush_d;
      end
   end

   always_comb begin
      perf_stall_cnt = perf_stall_q;
      perf_flush_cnt = perf_flush_q;
   end
`else
   always_comb begin
      perf_stall_cnt = '0;
      perf_flush_cnt = '0;
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed test-plan cases then random traffic.
module tb_pipe_hazard_ctrl;
   localparam int AW = 4;
   localparam int DC = 3;
   localparam int MT = 8;
   localparam int CW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, hlt, id_uses_rs, id_uses_rt;
   logic [AW-1:0] id_rs, id_rt, ex_rd;
   logic          ex_mem_read, ex_reg_write, br_taken, mem_busy;
   logic          pc_we, ifid_we, ifid_flush, idex_we, idex_bubble;
   logic          exmem_we, exmem_flush, memwb_bubble, stall, halted, mem_err;
   logic [1:0]    state;
   logic [CW-1:0] perf_stall_cnt, perf_flush_cnt;

   pipe_hazard_ctrl #(
      .REG_AW(AW), .DRAIN_CYCLES(DC), .MEM_TIMEOUT(MT), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .hlt(hlt),
      .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
      .br_taken(br_taken), .mem_busy(mem_busy),
      .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
      .idex_we(idex_we), .idex_bubble(idex_bubble),
      .exmem_we(exmem_we), .exmem_flush(exmem_flush),
      .memwb_bubble(memwb_bubble), .stall(stall), .halted(halted),
      .mem_err(mem_err), .state(state),
      .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
   );

   typedef struct {
      bit          rst, hlt, urs, urt, mr, rw, br, mb;
      bit [AW-1:0] rs, rt, rd;
   } stim_t;

   typedef struct {
      int            n;
      logic [12:0]   ctl;
      logic [CW-1:0] ps, pf;
   } exp_t;

   typedef enum int {A_RESET, A_FROZEN, A_WAIT, A_FLUSH, A_HOLD, A_FLOW} act_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   ncyc = 0;

   // reference state: mode 0 run, 1 drain, 2 halted, 3 error
   int m_mode = 0;
   int m_drain_left = 0;
   int m_busy_run = 0;
   bit m_err = 0;
   int m_pstall = 0;
   int m_pflush = 0;
   localparam int CMAX = (1 << CW) - 1;

   function automatic stim_t idle();
      stim_t s;
      s = '{default: 0};
      return s;
   endfunction

   task automatic apply(input stim_t s, input bit push);
      exp_t e;
      act_t a;
      bit   lu;
      bit [7:0] c;
      @(posedge clk);
      #1;
      rst = s.rst; hlt = s.hlt;
      id_rs = s.rs; id_rt = s.rt; ex_rd = s.rd;
      id_uses_rs = s.urs; id_uses_rt = s.urt;
      ex_mem_read = s.mr; ex_reg_write = s.rw;
      br_taken = s.br; mem_busy = s.mb;

      lu = s.mr && s.rw && (s.rd != 0) &&
           ((s.urs && s.rs == s.rd) || (s.urt && s.rt == s.rd));
      if (s.rst) a = A_RESET;
      else if (m_mode >= 2) a = A_FROZEN;
      else if (s.mb) a = A_WAIT;
      else if (s.br) a = A_FLUSH;
      else if (m_mode == 1 || lu || s.hlt) a = A_HOLD;
      else a = A_FLOW;

      // pc, ifid_we, ifid_fl, idex_we, idex_b, exmem_we, exmem_fl, memwb_b
      case (a)
         A_RESET:  c = 8'b0010_1011;
         A_FROZEN: c = 8'b0000_0000;
         A_WAIT:   c = 8'b0000_0001;
         A_FLUSH:  c = 8'b1111_1110;
         A_HOLD:   c = 8'b0001_1100;
         default:  c = 8'b1101_0100;
      endcase
      e.n   = ncyc;
      e.ctl = {c, ~c[7], a == A_FROZEN, m_err && !s.rst, 2'(m_mode)};
`ifdef PIPE_HAZARD_PERF_EN
      e.ps = CW'(m_pstall);
      e.pf = CW'(m_pflush);
`else
      e.ps = '0;
      e.pf = '0;
`endif
      if (push) q.push_back(e);
      ncyc++;

      if (s.rst) begin
         m_mode = 0; m_drain_left = 0; m_busy_run = 0;
         m_err = 0; m_pstall = 0; m_pflush = 0;
      end else if (a != A_FROZEN) begin
         if (!c[7] && m_pstall < CMAX) m_pstall++;
         if (a == A_FLUSH && m_pflush < CMAX) m_pflush++;
         if (a == A_WAIT) begin
            m_busy_run++;
            if (m_busy_run == MT) begin
               m_mode = 3;
               m_err = 1;
            end
         end else begin
            m_busy_run = 0;
            if (a == A_FLUSH) begin
               m_mode = 0;
            end else if (m_mode == 1) begin
               m_drain_left--;
               if (m_drain_left == 0) m_mode = 2;
            end else if (a == A_HOLD && !lu) begin
               m_mode = 1;
               m_drain_left = DC;
            end
         end
      end else begin
         m_busy_run = 0;
      end
   endtask

   initial begin
      exp_t e;
      logic [12:0] got;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            got = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble,
                   exmem_we, exmem_flush, memwb_bubble, stall, halted,
                   mem_err, state};
            total++;
            if (got !== e.ctl) begin
               bad++;
               $display("FAIL ctl cyc=%0d got=%b exp=%b", e.n, got, e.ctl);
            end
            total++;
            if ({perf_stall_cnt, perf_flush_cnt} !== {e.ps, e.pf}) begin
               bad++;
               $display("FAIL perf cyc=%0d got=%0d/%0d exp=%0d/%0d",
                        e.n, perf_stall_cnt, perf_flush_cnt, e.ps, e.pf);
            end
         end
      end
   end

   initial begin
      stim_t s;
      int burst;
      s = idle();
      s.rst = 1;
      apply(s, 0);
      apply(s, 1);
      s = idle();
      apply(s, 1);

      // load-use then release
      s = idle();
      s.mr = 1; s.rw = 1; s.rd = 5; s.rs = 5; s.urs = 1;
      apply(s, 1);
      s.mr = 0;
      apply(s, 1);
      // ex_rd = 0, then branch overriding load-use
      s = idle();
      s.mr = 1; s.rw = 1; s.rd = 0; s.rs = 0; s.urs = 1;
      apply(s, 1);
      s.rd = 5; s.rs = 5; s.br = 1;
      apply(s, 1);
      s = idle();
      apply(s, 1);

      // memory wait
      s.mb = 1;
      repeat (4) apply(s, 1);
      s = idle();
      apply(s, 1);

      // halt drain with a busy stall in the middle
      s.hlt = 1;
      apply(s, 1);
      s = idle();
      apply(s, 1);
      s.mb = 1;
      apply(s, 1);
      s = idle();
      repeat (4) apply(s, 1);
      s.mb = 1; s.br = 1; s.hlt = 1;
      apply(s, 1);
      s = idle();
      s.rst = 1;
      apply(s, 1);
      s = idle();
      apply(s, 1);

      // drain abort
      s.hlt = 1;
      apply(s, 1);
      s = idle();
      s.br = 1;
      apply(s, 1);
      s = idle();
      repeat (4) apply(s, 1);

      // watchdog
      s.rst = 1;
      apply(s, 1);
      s = idle();
      s.mb = 1;
      repeat (MT) apply(s, 1);
      s = idle();
      repeat (2) apply(s, 1);
      s.rst = 1;
      apply(s, 1);
      s = idle();
      apply(s, 1);

      burst = 0;
      for (int i = 0; i < 3000; i++) begin
         s.rst = ($urandom_range(0, 99) < ((m_mode >= 2) ? 15 : 1));
         s.hlt = ($urandom_range(0, 99) < 6);
         s.rs  = AW'($urandom_range(0, 3));
         s.rt  = AW'($urandom_range(0, 3));
         s.rd  = AW'($urandom_range(0, 3));
         s.urs = $urandom_range(0, 1) == 1;
         s.urt = $urandom_range(0, 1) == 1;
         s.mr  = ($urandom_range(0, 99) < 40);
         s.rw  = ($urandom_range(0, 99) < 80);
         s.br  = ($urandom_range(0, 99) < 10);
         if (burst == 0 && $urandom_range(0, 99) < 3) burst = $urandom_range(4, 10);
         if (burst > 0) begin
            s.mb = 1;
            burst--;
         end else begin
            s.mb = ($urandom_range(0, 99) < 12);
         end
         apply(s, 1);
      end

      repeat (3) @(posedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain_queue left=%0d exp=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage CPU (IF/ID/EX/MEM/WB).
- Generates per-stage write-enable, bubble and flush controls for load-use hazards, taken branches and data-memory wait.
- Runs the halt drain, which lets older instructions retire and then freezes the core.
- Adds a memory-busy watchdog that forces an error halt.

Parameters:
- REG_AW, 4: register-id width.
- DRAIN_CYCLES, 3: advancing cycles spent in DRAIN before HALTED (1..15).
- MEM_TIMEOUT, 255: consecutive mem_busy cycles that trigger ERROR (1..255).
- CNT_W, 16: perf counter width.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- hlt  in  1  HLT instruction currently in ID.
- id_rs  in  REG_AW  ID source reg 0.
- id_rt  in  REG_AW  ID source reg 1.
- id_uses_rs  in  1  ID reads id_rs.
- id_uses_rt  in  1  ID reads id_rt.
- ex_rd  in  REG_AW  EX destination reg.
- ex_mem_read  in  1  EX instr is a load.
- ex_reg_write  in  1  EX instr writes the register file.
- br_taken  in  1  redirect resolved in MEM this cycle.
- mem_busy  in  1  data memory not ready; MEM must hold.
- pc_we  out  1  PC update enable.
- ifid_we  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_we  out  1  ID/EX load enable.
- idex_bubble  out  1  ID/EX loads a NOP.
- exmem_we  out  1  EX/MEM load enable.
- exmem_flush  out  1  EX/MEM loads a NOP.
- memwb_bubble  out  1  MEM/WB loads a NOP.
- stall  out  1  equals ~pc_we.
- halted  out  1  core stopped.
- mem_err  out  1  sticky watchdog error.
- state  out  2  0=RUN, 1=DRAIN, 2=HALTED, 3=ERROR.
- perf_stall_cnt  out  CNT_W  see Optional Feature.
- perf_flush_cnt  out  CNT_W  see Optional Feature.

Behaviour:
- Outputs are combinational from state and inputs. State, counters and mem_err are registered.
- **Reset cycle** (rst=1): pc_we=0, all *_we=0, ifid_flush=exmem_flush=idex_bubble=memwb_bubble=1, stall=1, halted=0, mem_err=0. Next state is RUN, drain_cnt=0, busy_cnt=0.
- **Default (RUN, no event):** all *_we=1, all flush/bubble=0.
- **Load-use (lu):** ex_mem_read & ex_reg_write & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- Priority each cycle: mem_busy > br_taken > lu > hlt.
- **mem_busy=1 (any state except HALTED/ERROR):**
  - pc_we=ifid_we=idex_we=exmem_we=0, memwb_bubble=1, other flush/bubble=0.
  - busy_cnt increments (saturating). On the cycle busy_cnt reaches MEM_TIMEOUT-1 with mem_busy still high: next state ERROR, mem_err set.
  - busy_cnt clears whenever mem_busy=0.
- **br_taken (RUN or DRAIN):**
  - pc_we=1, ifid_flush=1, idex_bubble=1, exmem_flush=1.
  - lu and hlt ignored.
  - In DRAIN: drain aborted (the HLT was wrong-path), next state RUN.
- **lu (RUN):** pc_we=0, ifid_we=0, idex_bubble=1, EX/MEM/WB advance. One cycle only, since the load leaves EX.
- **hlt (RUN):**
  - pc_we=0, ifid_we=0, idex_bubble=1.
  - Next state DRAIN, drain_cnt=DRAIN_CYCLES.
- **DRAIN:**
  - Outputs as for hlt.
  - drain_cnt decrements on each cycle with mem_busy=0 and br_taken=0.
  - When drain_cnt==1 on such a cycle: next state HALTED.
  - Deassertion of hlt is ignored.
- **HALTED / ERROR:**
  - All *_we=0, all flush/bubble=0, halted=1.
  - Inputs ignored; exit only by rst.
- rst mid-DRAIN or mid-busy: reset-cycle behaviour, counters cleared.

Optional Feature:
- Macro PIPE_HAZARD_PERF_EN.
- **Defined:**
  - perf_stall_cnt counts cycles with pc_we=0 in RUN/DRAIN.
  - perf_flush_cnt counts br_taken flush cycles.
  - Both saturate at all-ones and clear on rst.
- **Undefined:** both ports are driven constant 0 and no counter flops exist.

Test Plan:
- **Load-use:** ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_rs=5, id_uses_rs=1 for one cycle -> pc_we=0, ifid_we=0, idex_bubble=1 that cycle; next cycle with ex_mem_read=0 -> all we=1.
- **ex_rd=0 hazard:** same stimulus as load-use but ex_rd=0 -> no stall. Same stimulus with br_taken=1 -> flush wins: pc_we=1, ifid_flush=idex_bubble=exmem_flush=1.
- **Memory wait:** mem_busy high 4 cycles -> 4 cycles of pc_we=exmem_we=0, memwb_bubble=1; state stays RUN; busy_cnt returns to 0.
- **Halt drain:** hlt 1 cycle, DRAIN_CYCLES=3, with mem_busy=1 on the 2nd DRAIN cycle -> HALTED entered after 3 non-busy DRAIN cycles; halted=1, state=2 thereafter; rst -> RUN.
- **Drain abort:** hlt, then br_taken during the first DRAIN cycle -> flush outputs, state back to RUN, halted stays 0.
- **Watchdog:** MEM_TIMEOUT=8, mem_busy held 8 cycles -> state=3, mem_err=1, halted=1; mem_busy drop has no effect; rst clears. With PIPE_HAZARD_PERF_EN, perf_stall_cnt=8.
